// File: rtl/mac_seq.sv
// Multiply-accumulate sequencer: feeds operand pairs to an external mul, sums products via an
// external combinational adder and emits the dot product. Optional macro MAC_SAT_EN saturates acc.
module mac_seq #(
    parameter int MAX_WAIT = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] acc_out,
    output logic        ovf,
    output logic        err,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_start,
    input  logic        mul_busy,
    input  logic [15:0] mul_result,
    output logic [15:0] sum_in_a,
    output logic [15:0] sum_in_b,
    input  logic [15:0] sum_out,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_valid is only looked at in IDLE; out_valid holds acc_out/ovf stable until out_ready.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_last;
    logic [15:0] r_prod;
    logic [15:0] r_acc;
    logic        r_ovf;
    logic        r_err;
    logic [CW-1:0] r_cnt;
    logic        w_carry;
    logic        w_timeout;

    assign w_carry   = (sum_out < r_acc);
    assign w_timeout = (r_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        acc_out   = 16'h0000;
        ovf       = 1'b0;
        sum_in_a  = 16'h0000;
        sum_in_b  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_START;
            end
            S_START: begin
                mul_start = 1'b1;
                w_next    = S_GUARD;
            end
            S_GUARD: w_next = S_WAIT;
            S_WAIT: begin
                if (!mul_busy)      w_next = S_ACC;
                else if (w_timeout) w_next = S_ERR;
            end
            S_ACC: begin
                sum_in_a = r_acc;
                sum_in_b = r_prod;
                w_next   = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                acc_out   = r_acc;
                ovf       = r_ovf;
                if (out_ready) w_next = S_IDLE;
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_last <= 1'b0;
            r_prod <= 16'h0000;
            r_acc  <= 16'h0000;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_last <= in_last;
                    end
                end
                S_GUARD: r_cnt <= '0;
                S_WAIT: begin
                    if (!mul_busy)      r_prod <= mul_result;
                    else if (w_timeout) r_err  <= 1'b1;
                    else                r_cnt  <= r_cnt + 1'b1;
                end
                S_ACC: begin
`ifdef MAC_SAT_EN
                    // Once saturated, the vector stays pinned at full scale.
                    if (w_carry || r_ovf) r_acc <= 16'hFFFF;
                    else                  r_acc <= sum_out;
`else
                    r_acc <= sum_out;
`endif
                    if (w_carry) r_ovf <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc <= 16'h0000;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
